// File: rtl/dma_pkg.sv
// Shared types and default constants for the page-copy DMA engine.
package dma_pkg;

  // Engine state: pass-through, waiting for the mpu to park, and the copy loop.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALT = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } dma_state_t;

  localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] DEF_DST_ADDR  = 16'h2004;
  localparam int          DEF_LEN       = 256;

  // The DMA drives the memory bus only while it is copying.
  function automatic logic dma_owns_bus(input dma_state_t st);
    return (st == RD) || (st == WR);
  endfunction

endpackage

// File: rtl/dma_bus_mux.sv
// Memory bus owner select: the mpu drives the bus unless the DMA holds it.
module dma_bus_mux (
  input  logic        dma_own,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_r_w,
  input  logic [7:0]  cpu_db_out,
  input  logic [15:0] dma_a,
  input  logic        dma_we,
  input  logic [7:0]  dma_wd,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [7:0]  mem_wd
);

  // Pure combinational select; the mpu read/write flag is active-high read.
  assign mem_a  = dma_own ? dma_a  : cpu_ab;
  assign mem_we = dma_own ? dma_we : ~cpu_r_w;
  assign mem_wd = dma_own ? dma_wd : cpu_db_out;

endmodule

// File: rtl/dma_ctrl.sv
// Page-copy DMA engine and bus arbiter between the mpu and shared memory.
// A write to TRIG_ADDR latches the source page, stalls the mpu, and copies
// LEN bytes from {page,8'h00} to the single port address DST_ADDR.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
  parameter logic [15:0] DST_ADDR  = DEF_DST_ADDR,
  parameter int          LEN       = DEF_LEN
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic [15:0] CPU_AB,
  input  logic        CPU_R_W,
  input  logic [7:0]  CPU_DB_OUT,
  output logic        RDY,
  output logic [15:0] MEM_A,
  output logic        MEM_WE,
  output logic [7:0]  MEM_WD,
  input  logic [7:0]  MEM_RD,
  output logic        BUSY
);

  // idx is 9 bits so LEN=256 ends at idx=255 without overflowing the compare.
  localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

  dma_state_t  state_reg;
  logic [8:0]  idx_reg;
  logic [7:0]  page_reg;
  logic [7:0]  data_reg;
  logic        rdy_reg;
  logic        busy_reg;

  logic [15:0] dma_a;
  logic        dma_we;

  // Copy FSM: trigger in IDLE, wait for a parked read in HALT, then RD/WR pairs.
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      page_reg  <= '0;
      data_reg  <= '0;
      rdy_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!CPU_R_W && (CPU_AB == TRIG_ADDR)) begin
            page_reg  <= CPU_DB_OUT;
            idx_reg   <= '0;
            rdy_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= HALT;
          end
        end
        HALT: begin
          // The mpu only halts on a read cycle, so pending writes are let through.
          if (CPU_R_W) begin
            state_reg <= RD;
          end
        end
        RD: begin
          data_reg  <= MEM_RD;
          state_reg <= WR;
        end
        WR: begin
          if (idx_reg == LAST_IDX) begin
            rdy_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            idx_reg   <= idx_reg + 9'd1;
            state_reg <= RD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // DMA-side bus values; the source address stays within the latched page.
  always_comb begin
    dma_we = (state_reg == WR);
    dma_a  = dma_we ? DST_ADDR : {page_reg, idx_reg[7:0]};
  end

  dma_bus_mux u_bus_mux (
    .dma_own    (dma_owns_bus(state_reg)),
    .cpu_ab     (CPU_AB),
    .cpu_r_w    (CPU_R_W),
    .cpu_db_out (CPU_DB_OUT),
    .dma_a      (dma_a),
    .dma_we     (dma_we),
    .dma_wd     (data_reg),
    .mem_a      (MEM_A),
    .mem_we     (MEM_WE),
    .mem_wd     (MEM_WD)
  );

  assign RDY  = rdy_reg;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench: the bench plays the mpu and two 64 KiB memories, one for a
// LEN=256 engine and one for a LEN=1 engine sharing the same mpu bus.
module tb_dma_ctrl;

  localparam logic [15:0] PARK = 16'h3000;
  localparam logic [15:0] DST  = 16'h2004;

  logic        CLK = 1'b0;
  logic        RES_N;
  logic [15:0] CPU_AB;
  logic        CPU_R_W;
  logic [7:0]  CPU_DB_OUT;

  logic        RDY, BUSY, MEM_WE;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_WD, MEM_RD;
  logic        RDY1, BUSY1, MEM_WE1;
  logic [15:0] MEM_A1;
  logic [7:0]  MEM_WD1, MEM_RD1;

  logic [7:0]  ram  [0:65535];
  logic [7:0]  ram1 [0:65535];

  int          tests_run = 0;
  int          tests_failed = 0;

  int          wr_cnt, rd_cnt, wr1_cnt;
  logic [7:0]  wr_log  [0:511];
  logic [7:0]  wr1_log [0:15];
  logic [15:0] last_rd;
  bit          saw_zero;

  always #5 CLK = ~CLK;

  dma_ctrl dut (
    .CLK(CLK), .RES_N(RES_N), .CPU_AB(CPU_AB), .CPU_R_W(CPU_R_W),
    .CPU_DB_OUT(CPU_DB_OUT), .RDY(RDY), .MEM_A(MEM_A), .MEM_WE(MEM_WE),
    .MEM_WD(MEM_WD), .MEM_RD(MEM_RD), .BUSY(BUSY)
  );

  dma_ctrl #(.LEN(1)) dut1 (
    .CLK(CLK), .RES_N(RES_N), .CPU_AB(CPU_AB), .CPU_R_W(CPU_R_W),
    .CPU_DB_OUT(CPU_DB_OUT), .RDY(RDY1), .MEM_A(MEM_A1), .MEM_WE(MEM_WE1),
    .MEM_WD(MEM_WD1), .MEM_RD(MEM_RD1), .BUSY(BUSY1)
  );

  assign MEM_RD  = ram[MEM_A];
  assign MEM_RD1 = ram1[MEM_A1];

  // Memory models plus bus monitors for destination writes and DMA reads.
  always @(posedge CLK) begin
    if (MEM_WE) begin
      ram[MEM_A] = MEM_WD;
      if (MEM_A == DST) begin
        if (wr_cnt < 512) wr_log[wr_cnt] = MEM_WD;
        wr_cnt = wr_cnt + 1;
      end
    end
    if (BUSY && !MEM_WE && (MEM_A != CPU_AB)) begin
      rd_cnt  = rd_cnt + 1;
      last_rd = MEM_A;
    end
    if (BUSY && (MEM_A == 16'h0000)) saw_zero = 1'b1;
    if (MEM_WE1) begin
      ram1[MEM_A1] = MEM_WD1;
      if (MEM_A1 == DST) begin
        if (wr1_cnt < 16) wr1_log[wr1_cnt] = MEM_WD1;
        wr1_cnt = wr1_cnt + 1;
      end
    end
  end

  task automatic clear_logs();
    wr_cnt = 0; rd_cnt = 0; wr1_cnt = 0; last_rd = 16'h0; saw_zero = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    CPU_AB = a; CPU_R_W = 1'b0; CPU_DB_OUT = d;
  endtask

  // Called at a negedge; parks the mpu on a read so HALT can exit.
  task automatic cpu_park();
    CPU_AB = PARK; CPU_R_W = 1'b1; CPU_DB_OUT = 8'h00;
  endtask

  // Counts negedges with BUSY high until both engines are idle.
  task automatic wait_done(output int n, output int n1, output bit timed_out);
    bit done = 1'b0;
    n = 0; n1 = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge CLK);
      if (BUSY) n++;
      if (BUSY1) n1++;
      if (!BUSY && !BUSY1) done = 1'b1;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    RES_N = 1'b0; CPU_AB = 16'h1234; CPU_R_W = 1'b1; CPU_DB_OUT = 8'h00;
    repeat (2) @(negedge CLK);
    tests_run++;
    if (RDY !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: RDY=%b BUSY=%b, want RDY=1 BUSY=0", RDY, BUSY);
    end
    tests_run++;
    if (MEM_A !== 16'h1234 || MEM_WE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_passthru_rd: MEM_A=%h MEM_WE=%b, want 1234/0", MEM_A, MEM_WE);
    end
    CPU_R_W = 1'b0; CPU_DB_OUT = 8'h5C; #1;
    tests_run++;
    if (MEM_WE !== 1'b1 || MEM_WD !== 8'h5C) begin
      tests_failed++;
      $display("FAIL reset_passthru_wr: MEM_WE=%b MEM_WD=%h, want 1/5c", MEM_WE, MEM_WD);
    end
    @(negedge CLK);
    CPU_R_W = 1'b1; RES_N = 1'b1;
    $display("[TB] reset: done");
  endtask

  task automatic test_basic_copy();
    int n, n1; bit to;
    clear_logs();
    cpu_write(16'h4014, 8'h02);
    @(negedge CLK);
    tests_run++;
    if (RDY !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_stall: RDY=%b BUSY=%b, want 0/1", RDY, BUSY);
    end
    tests_run++;
    if (ram[16'h4014] !== 8'h02) begin
      tests_failed++;
      $display("FAIL basic_trig_write: ram[4014]=%h, want 02", ram[16'h4014]);
    end
    cpu_park();
    wait_done(n, n1, to);
    tests_run++;
    if (to || n != 512) begin
      tests_failed++;
      $display("FAIL basic_busy_len: busy=%0d timeout=%b, want 512", n, to);
    end
    tests_run++;
    if (RDY !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_rdy_back: RDY=%b, want 1", RDY);
    end
    tests_run++;
    if (wr_cnt != 256) begin
      tests_failed++;
      $display("FAIL basic_wr_count: got %0d, want 256", wr_cnt);
    end
    for (int i = 0; i < 256; i++) begin
      tests_run++;
      if (wr_log[i] !== (8'(i) ^ 8'h5A)) begin
        tests_failed++;
        $display("FAIL basic_data[%0d]: got %h, want %h", i, wr_log[i], 8'(i) ^ 8'h5A);
      end
    end
    $display("[TB] basic copy page 02: %0d writes, busy %0d", wr_cnt, n);
  endtask

  task automatic test_halt_wait();
    int n, n1; bit to;
    clear_logs();
    cpu_write(16'h4014, 8'h02);
    cpu_write(16'h4014, 8'h03);
    cpu_write(16'h0300, 8'hC3);
    @(negedge CLK);
    tests_run++;
    if (rd_cnt != 0 || wr_cnt != 0 || RDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_no_dma: rd=%0d wr=%0d RDY=%b, want 0/0/0", rd_cnt, wr_cnt, RDY);
    end
    tests_run++;
    if (ram[16'h0300] !== 8'hC3 || ram[16'h4014] !== 8'h03) begin
      tests_failed++;
      $display("FAIL halt_cpu_writes: ram[0300]=%h ram[4014]=%h, want c3/03",
               ram[16'h0300], ram[16'h4014]);
    end
    cpu_park();
    wait_done(n, n1, to);
    tests_run++;
    if (to || wr_cnt != 256 || rd_cnt != 256) begin
      tests_failed++;
      $display("FAIL halt_counts: wr=%0d rd=%0d timeout=%b, want 256/256", wr_cnt, rd_cnt, to);
    end
    tests_run++;
    if (wr_log[0] !== 8'h5A || wr_log[255] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL halt_page_kept: first=%h last=%h, want 5a/a5", wr_log[0], wr_log[255]);
    end
    $display("[TB] halt wait: rd %0d wr %0d", rd_cnt, wr_cnt);
  endtask

  task automatic test_len1();
    int n, n1; bit to;
    clear_logs();
    cpu_write(16'h4014, 8'h10);
    @(negedge CLK);
    cpu_park();
    wait_done(n, n1, to);
    tests_run++;
    if (to || n1 != 2 || n != 512) begin
      tests_failed++;
      $display("FAIL len1_busy: busy1=%0d busy=%0d timeout=%b, want 2/512", n1, n, to);
    end
    tests_run++;
    if (wr1_cnt != 1 || wr1_log[0] !== 8'hA7 || ram1[DST] !== 8'hA7) begin
      tests_failed++;
      $display("FAIL len1_write: count=%0d data=%h mem=%h, want 1/a7/a7",
               wr1_cnt, wr1_log[0], ram1[DST]);
    end
    $display("[TB] len1 copy: %0d write, busy %0d", wr1_cnt, n1);
  endtask

  task automatic test_page_ff();
    int n, n1; bit to;
    clear_logs();
    cpu_write(16'h4014, 8'hFF);
    @(negedge CLK);
    cpu_park();
    wait_done(n, n1, to);
    tests_run++;
    if (to || rd_cnt != 256 || last_rd !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL pageff_reads: rd=%0d last=%h timeout=%b, want 256/ffff", rd_cnt, last_rd, to);
    end
    tests_run++;
    if (saw_zero) begin
      tests_failed++;
      $display("FAIL pageff_nowrap: saw access to 0000, want none");
    end
    $display("[TB] page ff: last read %h", last_rd);
  endtask

  task automatic test_mid_reset();
    clear_logs();
    cpu_write(16'h4014, 8'h02);
    @(negedge CLK);
    cpu_park();
    repeat (20) @(negedge CLK);
    tests_run++;
    if (MEM_WE !== 1'b1 || MEM_A !== DST || wr_cnt != 9) begin
      tests_failed++;
      $display("FAIL midrst_at_wr10: WE=%b A=%h wr=%0d, want 1/2004/9", MEM_WE, MEM_A, wr_cnt);
    end
    RES_N = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (RDY !== 1'b1 || BUSY !== 1'b0 || MEM_WE !== 1'b0 || wr_cnt != 10) begin
      tests_failed++;
      $display("FAIL midrst_abort: RDY=%b BUSY=%b WE=%b wr=%0d, want 1/0/0/10",
               RDY, BUSY, MEM_WE, wr_cnt);
    end
    @(negedge CLK);
    RES_N = 1'b1; CPU_AB = 16'hFFFC; CPU_R_W = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (MEM_A !== 16'hFFFC) begin
      tests_failed++;
      $display("FAIL midrst_vector: MEM_A=%h, want fffc", MEM_A);
    end
    repeat (20) @(negedge CLK);
    tests_run++;
    if (wr_cnt != 10 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: wr=%0d BUSY=%b, want 10/0", wr_cnt, BUSY);
    end
    $display("[TB] mid reset: %0d writes total", wr_cnt);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a] = 8'h00;
      ram1[a] = 8'h00;
    end
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
    ram1[16'h1000] = 8'hA7;
    clear_logs();
    test_reset();
    test_basic_copy();
    test_halt_wait();
    test_len1();
    test_page_ff();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
